// File: rtl/mips_dmem_pkg.sv
// Shared encodings and types for the sized MIPS data memory.
package mips_dmem_pkg;

  localparam int unsigned WAIT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        rd;
    logic        wr;
  } dmem_req_t;

endpackage

// File: rtl/mips_dmem_lane_unit.sv
// Byte-lane steering for the data memory: store enables/data, load extraction and
// extension, and alignment/size checks. Purely combinational.
module mips_dmem_lane_unit
  import mips_dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c,
  output logic        misalign_c,
  output logic        bad_size_c
);

  logic [31:0] rshift;

  // Store data is replicated across lanes; byte_en_c picks the live ones.
  always_comb begin
    byte_en_c  = 4'b0000;
    wdata_c    = 32'h0;
    rdata_c    = 32'h0;
    misalign_c = 1'b0;
    bad_size_c = 1'b0;
    rshift     = rword >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        byte_en_c = 4'(4'b0001 << addr_lo);
        wdata_c   = {4{wdata[7:0]}};
        rdata_c   = is_unsigned ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        misalign_c = addr_lo[0];
        byte_en_c  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = is_unsigned ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      end
      SZ_WORD: begin
        misalign_c = |addr_lo;
        byte_en_c  = 4'b1111;
        wdata_c    = wdata;
        rdata_c    = rword;
      end
      default: bad_size_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_data_mem_sized.sv
// Clocked MIPS data memory with sized accesses, wait states and error reporting.
// Optional err_count output when MIPS_DMEM_ERR_CNT_EN is defined.
module mips_data_mem_sized
  import mips_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] write_data,
  input  logic        sig_mem_read,
  input  logic        sig_mem_write,
  input  logic [1:0]  sig_mem_size,
  input  logic        sig_mem_unsigned,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [31:0] read_data,
  output logic        mem_error
`ifdef MIPS_DMEM_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned     HI        = AW + 2;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);
  localparam bit              ZERO_WAIT = (WAIT_STATES == 0);

  dmem_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  dmem_req_t         req_in, req_q, op;
  logic [31:0]       mem [DEPTH_WORDS];

  logic        busy_d, done_d, err_d;
  logic [31:0] rdata_d;
  logic        req_c, commit_c, reject_c, store_c, range_err_c;
  logic [AW-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wlane, rlane, rword;
  logic        misalign, bad_size;

  assign req_c  = sig_mem_read || sig_mem_write;
  assign req_in = '{addr: mem_address, wdata: write_data, size: sig_mem_size,
                    is_unsigned: sig_mem_unsigned, rd: sig_mem_read, wr: sig_mem_write};

  // With no wait states the request completes on its accept edge, straight from the inputs.
  assign op          = ZERO_WAIT ? req_in : req_q;
  assign idx         = op.addr[HI-1:2];
  assign range_err_c = (op.addr >> HI) != 32'h0;
  assign rword       = mem[idx];

  mips_dmem_lane_unit u_lane (
    .addr_lo     (op.addr[1:0]),
    .size        (op.size),
    .is_unsigned (op.is_unsigned),
    .wdata       (op.wdata),
    .rword       (rword),
    .byte_en_c   (byte_en),
    .wdata_c     (wlane),
    .rdata_c     (rlane),
    .misalign_c  (misalign),
    .bad_size_c  (bad_size)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = read_data;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (ZERO_WAIT) begin
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            busy_d  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_W'(1)) begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - WAIT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reject_c = (op.rd && op.wr) || bad_size || misalign || range_err_c;
    store_c  = commit_c && !reject_c && op.wr;
    if (commit_c) begin
      done_d = 1'b1;
      err_d  = reject_c;
      if (!reject_c && op.rd) rdata_d = rlane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_error <= 1'b0;
      read_data <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_busy  <= busy_d;
      mem_done  <= done_d;
      mem_error <= err_d;
      read_data <= rdata_d;
    end
  end

  // Request capture; not reset since it is only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_IDLE && req_c) req_q <= req_in;
  end

  // Storage is never cleared; a reset edge suppresses any commit.
  always_ff @(posedge clk) begin
    if (!rst && store_c) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

`ifdef MIPS_DMEM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= 8'h0;
    else if (err_d && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
